// File: rtl/mbist_pkg.sv
// Shared types for the March C- memory BIST controller: FSM states,
// element indices and the per-element operation table.
package mbist_pkg;

  typedef enum logic [2:0] {IDLE, RD, WT, WR, NXT, DONE} stateT;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;
  localparam logic [2:0] LAST_ELEM = M5;

  typedef struct packed {
    logic down;      // address order: 1 = DEPTH-1 .. 0
    logic hasRead;
    logic readVal;   // 0 = background, 1 = inverted background
    logic hasWrite;
    logic writeVal;
  } elemT;

  // Entries 6 and 7 are unreachable; they mirror M5 so every index decodes.
  localparam elemT ELEM_TABLE [0:7] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},   // M0 up   w0
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},   // M1 up   r0,w1
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},   // M2 up   r1,w0
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},   // M3 down r0,w1
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},   // M4 down r1,w0
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},   // M5 up   r0
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
  };

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter for the BIST walk; isLast flags the final
// address of the current element in its direction.
module mbist_addr_gen #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              load,
  input  logic              loadDown,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              isLast
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addrReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      addrReg <= '0;
    end else if (load) begin
      addrReg <= loadDown ? LAST_ADDR : '0;
    end else if (step) begin
      addrReg <= down ? addrReg - 1'b1 : addrReg + 1'b1;
    end
  end

  assign addr   = addrReg;
  assign isLast = down ? (addrReg == '0) : (addrReg == LAST_ADDR);

endmodule

// File: rtl/ram_mbist_ctrl.sv
// March C- BIST initiator for a single-port RAM with first-failure capture.
// Define MBIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module ram_mbist_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] BG = 8'h00
) (
  input  logic              CoreIN_CLK,
  input  logic              CoreIN_RESET,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic              ram_rx,
  output logic              ram_tx,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  import mbist_pkg::*;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT > 0 ? RD_LAT - 1 : 0);

  stateT             stateReg, stateNext;
  logic [2:0]        elemReg, elemNext;
  logic [1:0]        latCntReg, latCntNext;
  logic              busyReg, doneReg, ramRxReg, ramTxReg;
  logic [DATA_W-1:0] ramDinReg;
  logic              failReg;
  logic [ADDR_W-1:0] failAddrReg;
  logic [2:0]        failElemReg;
  logic [DATA_W-1:0] failDataReg;

  logic              agLoad, agLoadDown, agStep, agIsLast;
  logic [ADDR_W-1:0] agAddr;
  logic              compare, mismatch, readDone, advance, clearFlags;
  logic [DATA_W-1:0] expData;

  assign expData = ELEM_TABLE[elemReg].readVal ? ~BG : BG;

  mbist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk      (CoreIN_CLK),
    .rstN     (CoreIN_RESET),
    .load     (agLoad),
    .loadDown (agLoadDown),
    .step     (agStep),
    .down     (ELEM_TABLE[elemReg].down),
    .addr     (agAddr),
    .isLast   (agIsLast)
  );

  always_comb begin
    stateNext  = stateReg;
    elemNext   = elemReg;
    latCntNext = latCntReg;
    agLoad     = 1'b0;
    agLoadDown = 1'b0;
    agStep     = 1'b0;
    compare    = 1'b0;
    mismatch   = 1'b0;
    readDone   = 1'b0;
    advance    = 1'b0;
    clearFlags = 1'b0;

    case (stateReg)
      IDLE, DONE: begin
        if (start) begin
          clearFlags = 1'b1;
          elemNext   = M0;
          agLoad     = 1'b1;
          agLoadDown = ELEM_TABLE[M0].down;
          stateNext  = ELEM_TABLE[M0].hasRead ? RD : WR;
        end
      end
      RD: begin
        if (RD_LAT == 0) begin
          compare  = 1'b1;
          readDone = 1'b1;
        end else begin
          latCntNext = '0;
          stateNext  = WT;
        end
      end
      WT: begin
        if (latCntReg == LAT_LAST) begin
          compare  = 1'b1;
          readDone = 1'b1;
        end else begin
          latCntNext = latCntReg + 2'd1;
        end
      end
      WR:      advance = 1'b1;
      default: stateNext = IDLE;
    endcase

    if (readDone) begin
      if (ELEM_TABLE[elemReg].hasWrite) stateNext = WR;
      else                              advance   = 1'b1;
    end

    // Address/element advance happens in the same edge as the last operation.
    if (advance) begin
      if (agIsLast) begin
        if (elemReg == LAST_ELEM) begin
          stateNext = DONE;
        end else begin
          elemNext   = elemReg + 3'd1;
          agLoad     = 1'b1;
          agLoadDown = ELEM_TABLE[elemNext].down;
          stateNext  = ELEM_TABLE[elemNext].hasRead ? RD : WR;
        end
      end else begin
        agStep    = 1'b1;
        stateNext = ELEM_TABLE[elemReg].hasRead ? RD : WR;
      end
    end

    mismatch = compare && (ram_dout != expData);

`ifdef MBIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      stateNext = DONE;
      elemNext  = elemReg;
      agLoad    = 1'b0;
      agStep    = 1'b0;
    end
`endif
  end

  always_ff @(posedge CoreIN_CLK or negedge CoreIN_RESET) begin
    if (!CoreIN_RESET) begin
      stateReg    <= IDLE;
      elemReg     <= M0;
      latCntReg   <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      ramRxReg    <= 1'b0;
      ramTxReg    <= 1'b0;
      ramDinReg   <= '0;
      failReg     <= 1'b0;
      failAddrReg <= '0;
      failElemReg <= '0;
      failDataReg <= '0;
    end else begin
      stateReg  <= stateNext;
      elemReg   <= elemNext;
      latCntReg <= latCntNext;
      busyReg   <= (stateNext == RD) || (stateNext == WT) || (stateNext == WR);
      doneReg   <= (stateNext == DONE);
      ramRxReg  <= (stateNext == RD);
      ramTxReg  <= (stateNext == WR);
      if (stateNext == WR)
        ramDinReg <= ELEM_TABLE[elemNext].writeVal ? ~BG : BG;
      else
        ramDinReg <= '0;

      if (clearFlags) begin
        failReg     <= 1'b0;
        failAddrReg <= '0;
        failElemReg <= '0;
        failDataReg <= '0;
      end else if (mismatch && !failReg) begin
        failReg     <= 1'b1;
        failAddrReg <= agAddr;
        failElemReg <= elemReg;
        failDataReg <= ram_dout;
      end
    end
  end

  assign busy      = busyReg;
  assign done      = doneReg;
  assign fail      = failReg;
  assign fail_addr = failAddrReg;
  assign fail_elem = failElemReg;
  assign fail_data = failDataReg;
  assign ram_rx    = ramRxReg;
  assign ram_tx    = ramTxReg;
  assign ram_addr  = agAddr;
  assign ram_din   = ramDinReg;

endmodule
